// File: rtl/mux4_1_unstripe.sv
// rtl/mux4_1_unstripe.sv - 4:1 byte unstriper: four lane FIFOs read round-robin onto one stream
module mux4_1_unstripe #(
  parameter int BW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [BW-1:0] in0,
  input  logic [BW-1:0] in1,
  input  logic [BW-1:0] in2,
  input  logic [BW-1:0] in3,
  input  logic          valid_in0,
  input  logic          valid_in1,
  input  logic          valid_in2,
  input  logic          valid_in3,
  output logic [BW-1:0] out0,
  output logic          valid_out0,
  output logic [3:0]    overflow,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Lane storage and bookkeeping
  logic [BW-1:0] mem     [4][DEPTH];
  logic [AW-1:0] wr_ptr  [4];
  logic [AW-1:0] rd_ptr  [4];
  logic [CW-1:0] count   [4];
  logic [CW-1:0] count_nxt [4];
  logic [1:0]    sel;

  // Inputs are flattened into lane-indexed form; reset masks all pushes
  logic [BW-1:0] lane_data [4];
  logic [3:0]    lane_valid;
  logic [3:0]    lane_full;
  logic [3:0]    push;
  logic [3:0]    pop;
  logic [3:0]    drop;
  logic          pop_any;
  logic          empty_nxt;

  assign lane_data[0] = in0;
  assign lane_data[1] = in1;
  assign lane_data[2] = in2;
  assign lane_data[3] = in3;
  assign lane_valid   = {valid_in3, valid_in2, valid_in1, valid_in0} & {4{~reset}};

  // Pop decision from pre-edge counts (no bypass), then per-lane push/drop and next counts
  always_comb begin
    pop       = '0;
    push      = '0;
    drop      = '0;
    lane_full = '0;
    empty_nxt = 1'b1;
    count_nxt = '{default: '0};
    pop_any   = (count[sel] != '0);
    pop[sel]  = pop_any;
    for (int i = 0; i < 4; i++) begin
      lane_full[i] = (count[i] == FULL_CNT);
      // A full lane that is popped this edge frees a slot, so the push is accepted
      push[i]      = lane_valid[i] && (!lane_full[i] || pop[i]);
      drop[i]      = lane_valid[i] && lane_full[i] && !pop[i];
      count_nxt[i] = count[i] + CW'(push[i]) - CW'(pop[i]);
      if (count_nxt[i] != '0) begin
        empty_nxt = 1'b0;
      end
    end
  end

  // Lane memory writes; contents need no reset because counts gate every read
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= lane_data[i];
      end
    end
  end

  // Pointers, counts, selector and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      sel        <= '0;
      out0       <= '0;
      valid_out0 <= 1'b0;
      overflow   <= '0;
      empty      <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        // Pointer width equals log2(DEPTH), so natural rollover wraps modulo DEPTH
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
        count[i] <= count_nxt[i];
      end
      overflow   <= overflow | drop;
      empty      <= empty_nxt;
      valid_out0 <= pop_any;
      // An empty expected lane stalls the stream; out0 holds and sel stays put
      if (pop_any) begin
        out0 <= mem[sel][rd_ptr[sel]];
        sel  <= sel + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mux4_1_unstripe.sv
// tb/tb_mux4_1_unstripe.sv - self-checking bench for mux4_1_unstripe
module tb_mux4_1_unstripe;

  localparam int BW    = 8;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic [BW-1:0] in0, in1, in2, in3;
  logic          valid_in0, valid_in1, valid_in2, valid_in3;
  logic [BW-1:0] out0;
  logic          valid_out0;
  logic [3:0]    overflow;
  logic          empty;

  mux4_1_unstripe #(.BW(BW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .valid_in0  (valid_in0),
    .valid_in1  (valid_in1),
    .valid_in2  (valid_in2),
    .valid_in3  (valid_in3),
    .out0       (out0),
    .valid_out0 (valid_out0),
    .overflow   (overflow),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue per lane plus the lane index expected next
  logic [7:0] mq [4][$];
  int         m_sel   = 0;
  logic [7:0] e_out   = 8'h00;
  logic       e_valid = 1'b0;
  logic [3:0] e_ovf   = 4'b0000;
  logic       e_empty = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid_out0"}, {31'd0, valid_out0}, {31'd0, e_valid});
    check({tag, ".out0"}, {24'd0, out0}, {24'd0, e_out});
    check({tag, ".overflow"}, {28'd0, overflow}, {28'd0, e_ovf});
    check({tag, ".empty"}, {31'd0, empty}, {31'd0, e_empty});
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_sel   = 0;
    e_out   = 8'h00;
    e_valid = 1'b0;
    e_ovf   = 4'b0000;
    e_empty = 1'b1;
  endtask

  // One clock edge of the model: the head of the expected lane leaves first (if it
  // was there before the edge), then each valid byte joins its lane if there is room.
  task automatic model_edge(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] dd [4];
    dd[0] = d0; dd[1] = d1; dd[2] = d2; dd[3] = d3;
    if (mq[m_sel].size() > 0) begin
      e_out   = mq[m_sel].pop_front();
      e_valid = 1'b1;
      m_sel   = (m_sel + 1) % 4;
    end else begin
      e_valid = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(dd[i]);
        else e_ovf[i] = 1'b1;
      end
    end
    e_empty = 1'b1;
    for (int i = 0; i < 4; i++) if (mq[i].size() != 0) e_empty = 1'b0;
  endtask

  task automatic step(input string tag, input logic [3:0] v, input logic [7:0] d0,
                      input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
    in0 = d0; in1 = d1; in2 = d2; in3 = d3;
    valid_in0 = v[0]; valid_in1 = v[1]; valid_in2 = v[2]; valid_in3 = v[3];
    @(posedge clk);
    model_edge(v, d0, d1, d2, d3);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  // Reset raised between edges; outputs must clear before the next edge arrives
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check_outputs(tag);
    valid_in0 = 1'b1; valid_in1 = 1'b1; valid_in2 = 1'b1; valid_in3 = 1'b1;
    in0 = 8'hEE; in1 = 8'hEE; in2 = 8'hEE; in3 = 8'hEE;
    repeat (2) @(posedge clk);
    #1;
    check_outputs({tag, "_held"});
    @(negedge clk);
    reset = 1'b0;
    valid_in0 = 1'b0; valid_in1 = 1'b0; valid_in2 = 1'b0; valid_in3 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    valid_in0 = 1'b0; valid_in1 = 1'b0; valid_in2 = 1'b0; valid_in3 = 1'b0;
    #3;
    check_outputs("reset0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Ordering: one all-valid edge comes out as A0,A1,A2,A3 then empty
    step("order", 4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    idle("order_drain", 5);

    // Stall on empty lane 0 while lane 1 holds 55
    step("stall_push", 4'b0010, 8'h00, 8'h55, 8'h00, 8'h00);
    idle("stall_wait", 6);
    step("stall_l0", 4'b0001, 8'h10, 8'h00, 8'h00, 8'h00);
    idle("stall_drain", 3);

    // Asynchronous reset with bytes buffered, then lane 0 must be read first
    step("pre_rst", 4'b1110, 8'h00, 8'h21, 8'h22, 8'h23);
    async_reset("arst1");
    step("post_rst", 4'hF, 8'h31, 8'h32, 8'h33, 8'h34);
    idle("post_rst_drain", 5);

    // Overflow on lane 2 while lane 0 is empty
    for (int k = 1; k <= 5; k++) step("ovf_fill", 4'b0100, 8'h00, 8'h00, 8'(k), 8'h00);
    check("ovf_flag", {28'd0, overflow}, 32'h4);
    for (int k = 0; k < 4; k++)
      step("ovf_feed", 4'b1011, 8'(8'h40 + k), 8'(8'h50 + k), 8'h00, 8'(8'h70 + k));
    idle("ovf_drain", 14);

    // Full lane 0 popped and pushed on the same edge
    async_reset("arst2");
    step("full_first", 4'b0001, 8'h80, 8'h00, 8'h00, 8'h00);
    for (int k = 1; k <= DEPTH; k++) step("full_fill", 4'b0001, 8'(8'h80 + k), 8'h00, 8'h00, 8'h00);
    step("full_others", 4'b1110, 8'h00, 8'h91, 8'h92, 8'h93);
    idle("full_rot", 3);
    step("full_popush", 4'b0001, 8'h99, 8'h00, 8'h00, 8'h00);
    check("full_no_ovf", {28'd0, overflow}, 32'h0);
    idle("full_drain", DEPTH + 3);

    // Wrap-around: eight rounds, one all-valid edge every four cycles
    async_reset("arst3");
    for (int r = 0; r < 8; r++) begin
      step("wrap_push", 4'hF, 8'(4*r), 8'(4*r + 1), 8'(4*r + 2), 8'(4*r + 3));
      idle("wrap_gap", 3);
    end
    idle("wrap_drain", 3);
    check("wrap_no_ovf", {28'd0, overflow}, 32'h0);

    // Random traffic against the model, with a reset partway through
    async_reset("arst4");
    for (int k = 0; k < 300; k++) begin
      logic [3:0] v;
      v = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      if (k == 150) async_reset("arst_rand");
      step("rand", v, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    idle("rand_drain", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
